// File: rtl/banked_memory_pkg.sv
// Shared constants and types for the banked scratchpad memory.
// Holds the load/store control encoding, size codes and FSM states.
package banked_memory_pkg;

    localparam int REGISTER_WIDTH = 32;
    localparam int BYTE_W = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    // b_ctrl = {is_unsign, size[1:0]}; size[1] set means full word
    typedef struct packed {
        logic       is_unsign;
        logic [1:0] size;
    } b_ctrl_t;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } mem_state_e;

    function automatic int unsigned access_bytes(
        input logic [1:0]  size,
        input int unsigned lanes
    );
        if (size[1])
            return lanes;
        else if (size == SZ_BYTE)
            return 1;
        else
            return 2;
    endfunction

endpackage

// File: rtl/banked_memory_mem_bank.sv
// One byte-wide lane of storage: read port plus read/write port.
// Ports: clk, rst_n, r_* (read port), rw_* (read/write port); 1-cycle reads.
module mem_bank #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r_en,
    input  logic [AW-1:0] r_addr,
    output logic [7:0]    r_data,
    input  logic          rw_en,
    input  logic          rw_we,
    input  logic [AW-1:0] rw_addr,
    input  logic [7:0]    rw_wdata,
    output logic [7:0]    rw_rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rw_en && rw_we)
            mem[rw_addr] <= rw_wdata;
    end

    // Read registers only move on an enabled read, so data holds
    // between responses. Reads see pre-write contents (read-first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            rw_rdata <= '0;
        end else begin
            if (r_en)
                r_data <= mem[r_addr];
            if (rw_en && !rw_we)
                rw_rdata <= mem[rw_addr];
        end
    end

endmodule

// File: rtl/banked_memory.sv
// Byte-banked memory: port A word fetch, port B load/store with
// misaligned single-cycle spans. Clears itself after reset (init_busy).
module banked_memory
    import banked_memory_pkg::*;
#(
    parameter int DATA_W           = REGISTER_WIDTH,
    parameter int ADDR_W           = 32,
    parameter int DEPTH_WORDS      = 64,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_valid,
    output logic              a_error,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [2:0]        b_ctrl,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_done,
    output logic              b_error,
    output logic              init_busy
);

    localparam int LANES  = DATA_W / BYTE_W;
    localparam int LANE_W = $clog2(LANES);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int WIDX_W = ADDR_W - LANE_W;

    mem_state_e       state;
    logic [IDX_W-1:0] clr_cnt;

    logic              a_zero;
    logic              l_zero;
    logic [LANE_W-1:0] l_off;
    b_ctrl_t           l_ctrl;

    logic a_acc;
    logic b_acc;
    logic run;

    assign run   = (state == ST_RUN);
    assign a_acc = a_req && run;
    assign b_acc = b_req && run;

    // Port A decode
    logic [WIDX_W-1:0] a_widx;
    logic              a_oor;
    logic              unused_a_lo;

    assign a_widx      = a_addr[ADDR_W-1:LANE_W];
    assign a_oor       = a_widx >= WIDX_W'(DEPTH_WORDS);
    assign unused_a_lo = &{1'b0, a_addr[LANE_W-1:0]};

    // Port B decode
    b_ctrl_t           ctrl;
    logic [LANE_W-1:0] b_off;
    logic [WIDX_W-1:0] b_w;
    logic [LANE_W:0]   b_nb;
    logic              b_span;
    logic              b_oor;
    logic              b_mis;
    logic              b_err;

    assign ctrl  = b_ctrl_t'(b_ctrl);
    assign b_off = b_addr[LANE_W-1:0];
    assign b_w   = b_addr[ADDR_W-1:LANE_W];
    assign b_nb  = (LANE_W+1)'(access_bytes(ctrl.size, LANES));

    // Access runs into word w+1 when it crosses the lane boundary
    assign b_span = ({1'b0, b_off} + b_nb) > (LANE_W+1)'(LANES);
    assign b_oor  = (b_w >= WIDX_W'(DEPTH_WORDS))
                 || (b_span && (b_w >= WIDX_W'(DEPTH_WORDS - 1)));
    assign b_mis  = (ALLOW_MISALIGNED == 0)
                 && (((ctrl.size == SZ_HALF) && b_addr[0])
                  || (ctrl.size[1] && (b_off != '0)));
    assign b_err  = b_oor || b_mis;

    // Per-lane address, enable and store byte
    logic [LANES-1:0]            lane_on;
    logic [LANES-1:0][IDX_W-1:0] lane_idx;
    logic [LANES-1:0][7:0]       lane_wd;

    always_comb begin
        logic [LANE_W-1:0] rel;
        rel      = '0;
        lane_on  = '0;
        lane_idx = '0;
        lane_wd  = '0;
        for (int i = 0; i < LANES; i++) begin
            // rel = byte position of lane i within the access
            rel         = LANE_W'(i) - b_off;
            lane_on[i]  = {1'b0, rel} < b_nb;
            lane_idx[i] = b_w[IDX_W-1:0]
                        + IDX_W'(LANE_W'(i) < b_off);
            lane_wd[i]  = b_wdata[{rel, 3'b000} +: 8];
        end
    end

    // Bank port B: owned by the clear sequencer during INIT
    logic [LANES-1:0]            bk_en;
    logic [LANES-1:0]            bk_we;
    logic [LANES-1:0][IDX_W-1:0] bk_addr;
    logic [LANES-1:0][7:0]       bk_wd;
    logic [LANES-1:0][7:0]       a_q;
    logic [LANES-1:0][7:0]       b_q;

    always_comb begin
        bk_en   = '0;
        bk_we   = '0;
        bk_addr = '0;
        bk_wd   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!run) begin
                bk_en[i]   = 1'b1;
                bk_we[i]   = 1'b1;
                bk_addr[i] = clr_cnt;
            end else begin
                bk_en[i]   = b_acc
                           && (!b_we || (lane_on[i] && !b_err));
                bk_we[i]   = b_we;
                bk_addr[i] = lane_idx[i];
                bk_wd[i]   = lane_wd[i];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_bank
        mem_bank #(
            .DEPTH (DEPTH_WORDS),
            .AW    (IDX_W)
        ) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .r_en     (a_acc),
            .r_addr   (a_widx[IDX_W-1:0]),
            .r_data   (a_q[g]),
            .rw_en    (bk_en[g]),
            .rw_we    (bk_we[g]),
            .rw_addr  (bk_addr[g]),
            .rw_wdata (bk_wd[g]),
            .rw_rdata (b_q[g])
        );
    end

    // Control FSM and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            clr_cnt   <= '0;
            init_busy <= 1'b1;
            a_valid   <= 1'b0;
            a_error   <= 1'b0;
            a_zero    <= 1'b0;
            b_done    <= 1'b0;
            b_error   <= 1'b0;
            l_zero    <= 1'b0;
            l_off     <= '0;
            l_ctrl    <= '0;
        end else begin
            a_valid <= a_acc;
            a_error <= a_acc && a_oor;
            b_done  <= b_acc;
            b_error <= b_acc && b_err;
            if (a_acc)
                a_zero <= a_oor;
            if (b_acc && !b_we) begin
                l_zero <= b_err;
                l_off  <= b_off;
                l_ctrl <= ctrl;
            end
            unique case (state)
                ST_INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == IDX_W'(DEPTH_WORDS - 1)) begin
                        state     <= ST_RUN;
                        init_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    assign a_rdata = a_zero ? '0 : a_q;

    // Rotate so the addressed byte lands in [7:0], then extend
    logic [DATA_W-1:0] rot;

    always_comb begin
        rot = '0;
        for (int k = 0; k < LANES; k++)
            rot[k*8 +: 8] = b_q[LANE_W'(l_off + LANE_W'(k))];
    end

    always_comb begin
        b_rdata = rot;
        if (l_zero)
            b_rdata = '0;
        else if (l_ctrl.size[1])
            b_rdata = rot;
        else if (l_ctrl.size == SZ_HALF)
            b_rdata = {{(DATA_W-16){!l_ctrl.is_unsign && rot[15]}},
                       rot[15:0]};
        else
            b_rdata = {{(DATA_W-8){!l_ctrl.is_unsign && rot[7]}},
                       rot[7:0]};
    end

endmodule

// File: tb/tb_banked_memory.sv
// Scoreboard bench for banked_memory (default parameters) plus a second
// instance with misaligned accesses disallowed.
module tb_banked_memory;

    logic        clk;
    logic        rst_n;
    logic        a_req;
    logic [31:0] a_addr;
    logic        b_req;
    logic        b_we;
    logic [2:0]  b_ctrl;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;

    logic [31:0] a_rdata, b_rdata;
    logic        a_valid, a_error, b_done, b_error, init_busy;
    logic [31:0] a_rdata0, b_rdata0;
    logic        a_valid0, a_error0, b_done0, b_error0, init_busy0;

    banked_memory dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_rdata   (a_rdata),
        .a_valid   (a_valid),
        .a_error   (a_error),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_ctrl    (b_ctrl),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_rdata   (b_rdata),
        .b_done    (b_done),
        .b_error   (b_error),
        .init_busy (init_busy)
    );

    banked_memory #(.ALLOW_MISALIGNED(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_rdata   (a_rdata0),
        .a_valid   (a_valid0),
        .a_error   (a_error0),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_ctrl    (b_ctrl),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_rdata   (b_rdata0),
        .b_done    (b_done0),
        .b_error   (b_error0),
        .init_busy (init_busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        e;
        logic        ld;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mm [256];
    logic [31:0] last_a, last_b;
    bit          b_hold;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++)
            mm[i] = 8'h00;
    endtask

    function automatic int nbytes(input logic [2:0] c);
        return c[1] ? 4 : (c[0] ? 2 : 1);
    endfunction

    task automatic issue_a(input logic [31:0] addr);
        exp_t e;
        int   idx;
        a_req  = 1'b1;
        a_addr = addr;
        idx    = int'(addr >> 2);
        e.ld   = 1'b1;
        e.e    = (addr >> 2) >= 32'd64;
        e.d    = '0;
        if (!e.e)
            for (int k = 0; k < 4; k++)
                e.d[k*8 +: 8] = mm[idx*4 + k];
        qa.push_back(e);
    endtask

    task automatic issue_b(input logic we, input logic [2:0] c,
                           input logic [31:0] addr,
                           input logic [31:0] wd);
        exp_t        e;
        int          n;
        logic [31:0] raw;
        b_req   = 1'b1;
        b_we    = we;
        b_ctrl  = c;
        b_addr  = addr;
        b_wdata = wd;
        n       = nbytes(c);
        e.e     = (addr + 32'(n) - 32'd1) >= 32'd256;
        e.ld    = !we;
        e.d     = '0;
        raw     = '0;
        if (!e.e) begin
            for (int k = 0; k < n; k++) begin
                if (we)
                    mm[int'(addr) + k] = wd[k*8 +: 8];
                else
                    raw[k*8 +: 8] = mm[int'(addr) + k];
            end
        end
        if (!we && !e.e) begin
            if (n == 1)
                e.d = c[2] ? {24'h0, raw[7:0]}
                           : {{24{raw[7]}}, raw[7:0]};
            else if (n == 2)
                e.d = c[2] ? {16'h0, raw[15:0]}
                           : {{16{raw[15]}}, raw[15:0]};
            else
                e.d = raw;
        end
        qb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic measure_init(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (init_busy && cnt < 200);
    endtask

    // Response monitor: pops scoreboard on strobes, checks holds otherwise
    always @(negedge clk) begin
        if (!rst_n) begin
            last_a = '0;
            last_b = '0;
            b_hold = 1'b1;
        end else begin
            if (a_valid) begin
                if (qa.size() == 0) begin
                    check("a_spurious", 32'(a_valid), 32'd0);
                end else begin
                    ea = qa.pop_front();
                    check("a_rdata", a_rdata, ea.d);
                    check("a_error", 32'(a_error), 32'(ea.e));
                    last_a = ea.d;
                end
            end else begin
                check("a_rdata_hold", a_rdata, last_a);
                check("a_error_idle", 32'(a_error), 32'd0);
            end
            if (b_done) begin
                if (qb.size() == 0) begin
                    check("b_spurious", 32'(b_done), 32'd0);
                end else begin
                    eb = qb.pop_front();
                    check("b_error", 32'(b_error), 32'(eb.e));
                    if (eb.ld) begin
                        check("b_rdata", b_rdata, eb.d);
                        last_b = eb.d;
                        b_hold = 1'b1;
                    end else begin
                        b_hold = 1'b0;
                    end
                end
            end else begin
                if (b_hold)
                    check("b_rdata_hold", b_rdata, last_b);
                check("b_error_idle", 32'(b_error), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n   = 1'b1;
        a_req   = 1'b0;
        a_addr  = '0;
        b_req   = 1'b0;
        b_we    = 1'b0;
        b_ctrl  = '0;
        b_addr  = '0;
        b_wdata = '0;
        model_clear();
        #1 rst_n = 1'b0;
        #3;
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_b_done", 32'(b_done), 32'd0);
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_b_rdata", b_rdata, 32'd0);
        check("rst_init_busy", 32'(init_busy), 32'd1);

        // Requests held during INIT must be ignored (store of ones)
        a_req   = 1'b1;
        a_addr  = 32'h10;
        b_req   = 1'b1;
        b_we    = 1'b1;
        b_ctrl  = 3'b010;
        b_addr  = 32'h10;
        b_wdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        measure_init(cnt);
        a_req = 1'b0;
        b_req = 1'b0;
        check("init_cycles", 32'(cnt), 32'd64);
        check("init_busy0", 32'(init_busy0), 32'd0);
        @(negedge clk);

        issue_b(1'b0, 3'b010, 32'h10, 32'h0);
        tick();

        issue_b(1'b1, 3'b010, 32'h20, 32'h80FF_7F01);
        tick();
        issue_b(1'b0, 3'b000, 32'h23, 32'h0);
        tick();
        issue_b(1'b0, 3'b101, 32'h22, 32'h0);
        tick();
        issue_b(1'b0, 3'b001, 32'h21, 32'h0);
        tick();

        // Misaligned word store spanning words 1 and 2
        issue_b(1'b1, 3'b010, 32'h05, 32'hAABB_CCDD);
        tick();
        check("nomis_b_done", 32'(b_done0), 32'd1);
        check("nomis_b_error", 32'(b_error0), 32'd1);
        issue_a(32'h04);
        tick();
        check("nomis_unchanged", a_rdata0, 32'd0);
        issue_a(32'h08);
        tick();
        issue_b(1'b0, 3'b010, 32'h05, 32'h0);
        tick();
        issue_b(1'b0, 3'b001, 32'h07, 32'h0);
        tick();

        // Range boundaries
        issue_a(32'h100);
        tick();
        issue_b(1'b1, 3'b010, 32'hFE, 32'h1234_5678);
        tick();
        issue_b(1'b1, 3'b000, 32'hFF, 32'h0000_00C3);
        tick();
        issue_a(32'hFC);
        tick();
        issue_b(1'b0, 3'b100, 32'hFF, 32'h0);
        tick();
        issue_b(1'b0, 3'b010, 32'h100, 32'h0);
        tick();

        // Same-edge store and fetch: fetch sees old contents
        issue_a(32'h30);
        issue_b(1'b1, 3'b010, 32'h30, 32'h1234_5678);
        tick();
        issue_a(32'h30);
        tick();

        // Back-to-back fetches and loads every cycle
        for (int i = 0; i < 4; i++) begin
            issue_a(32'h20 + 32'(i) * 32'd4);
            issue_b(1'b0, 3'b010, 32'h2E + 32'(i), 32'h0);
            if (i < 3)
                @(negedge clk);
        end
        tick();

        // Reset mid-load: pending response dropped
        issue_a(32'h30);
        issue_b(1'b0, 3'b010, 32'h30, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_b_done", 32'(b_done), 32'd0);
        check("mid_b_rdata", b_rdata, 32'd0);
        check("mid_a_valid", 32'(a_valid), 32'd0);
        check("mid_a_rdata", a_rdata, 32'd0);
        check("mid_init_busy", 32'(init_busy), 32'd1);
        qa.delete();
        qb.delete();
        a_req = 1'b0;
        b_req = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Reset again part-way through the clear
        repeat (10) @(posedge clk);
        #1;
        check("partial_busy", 32'(init_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reinit_busy", 32'(init_busy), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        measure_init(cnt);
        check("reinit_cycles", 32'(cnt), 32'd64);
        @(negedge clk);
        issue_b(1'b0, 3'b010, 32'h30, 32'h0);
        tick();
        issue_a(32'h20);
        tick();
        repeat (2) @(negedge clk);

        check("qa_drained", 32'(qa.size()), 32'd0);
        check("qb_drained", 32'(qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/banked_memory.md
BANKED_MEMORY -- requirements
Module: banked_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits, a multiple of 8; LANES = DATA_W/8.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter DEPTH_WORDS, default 64, words per bank set, a power of two.
REQ-004 SHALL have parameter ALLOW_MISALIGNED, default 1; when 0, misaligned port-B accesses raise an error.
REQ-005 Ports SHALL be as follows (name, direction, width, meaning):
  clk  in  1  single clock, rising edge.
  rst_n  in  1  reset, asynchronous, active-low.
  a_req  in  1  fetch request.
  a_addr  in  ADDR_W  fetch byte address; low log2(LANES) bits ignored.
  a_rdata  out  DATA_W  fetch data.
  a_valid  out  1  fetch response strobe.
  a_error  out  1  fetch out of range.
  b_req  in  1  load/store request.
  b_we  in  1  1 = store, 0 = load.
  b_ctrl  in  3  {is_unsign, size[1:0]}: 00 byte, 01 half, 1x word.
  b_addr  in  ADDR_W  byte address.
  b_wdata  in  DATA_W  store data, LSB-aligned.
  b_rdata  out  DATA_W  load data, extended.
  b_done  out  1  load/store completion strobe.
  b_error  out  1  access error, valid with b_done.
  init_busy  out  1  memory clear in progress.

Function
REQ-006 SHALL hold a control FSM with states INIT and RUN.
REQ-007 In INIT, SHALL write zero to all lanes of word index 0..DEPTH_WORDS-1, one word per cycle, then enter RUN; init_busy=1 throughout INIT.
REQ-008 While init_busy=1, SHALL ignore a_req and b_req and assert no a_valid or b_done.
REQ-009 Port A SHALL accept a_req every cycle in RUN; a_valid=1 exactly one cycle after acceptance, with a_rdata holding the word at index a_addr[..]/LANES.
REQ-010 If the fetch word index >= DEPTH_WORDS, SHALL return a_valid=1, a_error=1 and a_rdata=0.
REQ-011 Port B SHALL accept b_req every cycle in RUN; b_done=1 exactly one cycle after acceptance for both loads and stores, with b_error valid in the same cycle.
REQ-012 A store SHALL commit on the accepting edge, writing only the lanes selected by size and b_addr low bits.
REQ-013 Lane i SHALL address word index w+1 when i < b_addr[log2(LANES)-1:0], otherwise word index w, so that a misaligned access spanning two words completes in one cycle.
REQ-014 Load data SHALL be rotated so the byte at b_addr lands in bits [7:0]; byte and half loads SHALL be sign-extended when is_unsign=0 and zero-extended when is_unsign=1; word loads SHALL be unextended.
REQ-015 b_error=1 SHALL be raised on: any touched word index >= DEPTH_WORDS (including a span wrap past the last word); or, with ALLOW_MISALIGNED=0, a half at an odd address or a word not aligned to LANES.
REQ-016 On an errored store, no lane SHALL be written; on an errored load, b_rdata=0.
REQ-017 When port A reads a word that port B writes on the same edge, a_rdata SHALL return the old data (read-first).
REQ-018 Between responses, a_rdata and b_rdata SHALL hold their last value; a_valid, b_done, a_error and b_error SHALL be single-cycle pulses.

Reset
REQ-019 Asserting rst_n=0 SHALL asynchronously clear a_valid, a_error, b_done, b_error, a_rdata and b_rdata to 0, set init_busy=1, and place the FSM in INIT with the clear counter at 0.
REQ-020 Reset during INIT or RUN SHALL drop any pending response, and the clear SHALL restart from word 0 after release.

Structure
REQ-021 The b_ctrl encoding, the size codes and the width/lane constants SHALL live in the shared main_memory.h header; REGISTER_WIDTH SHALL come from core.h.
REQ-022 Storage SHALL be LANES instances of the sub-module mem_bank: a dual-port byte RAM with one read port and one read/write port and 1-cycle registered read, of depth DEPTH_WORDS.

Verification
REQ-023 Reset release with default parameters -> init_busy high for exactly 64 cycles; a load from 0x10 then returns 0x00000000.
REQ-024 Store word 0x80FF7F01 at 0x20, then load byte signed at 0x23 -> 0xFFFFFF80; load half unsigned at 0x22 -> 0x000080FF.
REQ-025 Store word 0xAABBCCDD at 0x05 (ALLOW_MISALIGNED=1) -> fetch 0x04 returns 0xBBCCDD00 and fetch 0x08 returns 0x000000AA; with ALLOW_MISALIGNED=0, the same store gives b_error=1 and memory is unchanged.
REQ-026 Fetch at 0x100 with 64 words -> a_valid=1, a_error=1, a_rdata=0; a word store at 0xFE -> b_error=1 and no write.
REQ-027 Same-cycle store 0x12345678 at 0x30 and fetch of 0x30 -> fetch returns the old value; the next fetch returns 0x12345678.
REQ-028 Assert rst_n=0 mid-load and mid-INIT -> outputs are 0 immediately, no b_done follows, and INIT restarts at word 0.
